// File: rtl/array_arb_pkg.sv
// Shared types and default geometry for the two-master array access arbiter.
package array_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam int DEF_DEPTH = 8;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_AW    = 3;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone requester always wins, a tie goes to the
// requester that was not granted last.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_gnt,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = req;
        if (&req) begin
            gnt = last_gnt ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/array_access_arbiter.sv
// Register array shared by two masters; one access at a time through an
// IDLE -> ACCESS -> RESP handshake with round-robin arbitration.
module array_access_arbiter
    import array_arb_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int WIDTH = DEF_WIDTH,
    parameter int AW    = DEF_AW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic             we0,
    input  logic [AW-1:0]    addr0,
    input  logic [WIDTH-1:0] wdata0,
    input  logic [WIDTH-1:0] wmask0,
    output logic             done0,
    input  logic             req1,
    input  logic             we1,
    input  logic [AW-1:0]    addr1,
    input  logic [WIDTH-1:0] wdata1,
    input  logic [WIDTH-1:0] wmask1,
    output logic             done1,
    output logic [WIDTH-1:0] rdata,
    output logic             err,
    output logic             busy
);

    localparam logic [AW:0] DEPTH_LIM = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    state_t           state;
    logic             last_gnt;
    logic [1:0]       gnt;

    logic             win_we;
    logic [AW-1:0]    win_addr;
    logic [WIDTH-1:0] win_wdata;
    logic [WIDTH-1:0] win_wmask;
    logic             win_oor;

    logic             cmd_we;
    logic             cmd_id;
    logic             cmd_oor;
    logic [AW-1:0]    cmd_addr;
    logic [WIDTH-1:0] cmd_wdata;
    logic [WIDTH-1:0] cmd_wmask;

    rr_arb2 u_rr_arb2 (
        .req      ({req1, req0}),
        .last_gnt (last_gnt),
        .gnt      (gnt)
    );

    always_comb begin
        win_we    = gnt[1] ? we1    : we0;
        win_addr  = gnt[1] ? addr1  : addr0;
        win_wdata = gnt[1] ? wdata1 : wdata0;
        win_wmask = gnt[1] ? wmask1 : wmask0;
        win_oor   = ({1'b0, win_addr} >= DEPTH_LIM);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            last_gnt  <= 1'b1;
            done0     <= 1'b0;
            done1     <= 1'b0;
            err       <= 1'b0;
            busy      <= 1'b0;
            rdata     <= '0;
            cmd_we    <= 1'b0;
            cmd_id    <= 1'b0;
            cmd_oor   <= 1'b0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
            cmd_wmask <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            done0 <= 1'b0;
            done1 <= 1'b0;
            err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (|gnt) begin
                        cmd_we    <= win_we;
                        cmd_addr  <= win_addr;
                        cmd_wdata <= win_wdata;
                        cmd_wmask <= win_wmask;
                        cmd_oor   <= win_oor;
                        cmd_id    <= gnt[1];
                        last_gnt  <= gnt[1];
                        busy      <= 1'b1;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    // Out-of-range commands never touch the array; reads return zero.
                    if (cmd_we) begin
                        if (!cmd_oor) begin
                            mem[cmd_addr] <= (mem[cmd_addr] & ~cmd_wmask) | (cmd_wdata & cmd_wmask);
                        end
                    end else begin
                        rdata <= cmd_oor ? '0 : mem[cmd_addr];
                    end
                    done0 <= ~cmd_id;
                    done1 <= cmd_id;
                    err   <= cmd_oor;
                    state <= RESP;
                end
                RESP: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_array_access_arbiter.sv
// Bench for array_access_arbiter (DEPTH=6 so out-of-range addresses exist):
// vector table, directed multi-cycle sequences and randomized two-master rounds.
module tb_array_access_arbiter;

    localparam int DEPTH = 6;
    localparam int WIDTH = 8;
    localparam int AW    = 3;

    typedef struct {
        logic       we;
        logic [2:0] addr;
        logic [7:0] wdata;
        logic [7:0] wmask;
    } cmd_t;

    typedef struct {
        int         id;
        cmd_t       c;
        logic [7:0] exp_rd;
        logic       exp_err;
    } vec_t;

    logic       clk = 0;
    logic       rst_n = 0;
    logic       req0 = 0, we0 = 0, req1 = 0, we1 = 0;
    logic [2:0] addr0 = 0, addr1 = 0;
    logic [7:0] wdata0 = 0, wmask0 = 0, wdata1 = 0, wmask1 = 0;
    logic       done0, done1, err, busy;
    logic [7:0] rdata;

    int errors = 0;
    int checks = 0;

    logic [7:0] model_mem [8];
    int         model_last;

    array_access_arbiter #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AW(AW)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req0   (req0),
        .we0    (we0),
        .addr0  (addr0),
        .wdata0 (wdata0),
        .wmask0 (wmask0),
        .done0  (done0),
        .req1   (req1),
        .we1    (we1),
        .addr1  (addr1),
        .wdata1 (wdata1),
        .wmask1 (wmask1),
        .done1  (done1),
        .rdata  (rdata),
        .err    (err),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) model_mem[i] = 8'h00;
        model_last = 1;
    endtask

    task automatic model_apply(input cmd_t c, output logic [7:0] rd, output logic er);
        er = (c.addr >= DEPTH);
        rd = 8'h00;
        if (!er) begin
            if (c.we) model_mem[c.addr] = (model_mem[c.addr] & ~c.wmask) | (c.wdata & c.wmask);
            else      rd = model_mem[c.addr];
        end
    endtask

    // Raise the selected requests together, then act as both masters until every
    // request has completed; each master drops its req in the cycle it sees done.
    task automatic do_round(input logic r0, input logic r1, input cmd_t c0, input cmd_t c1,
                            output logic [7:0] obs_rd, output logic obs_err);
        int         order[$];
        cmd_t       cc[2];
        logic [7:0] exp_rd[2];
        logic       exp_er[2];
        int         got;
        int         cyc;
        int         id;
        cc[0] = c0;
        cc[1] = c1;
        if (r0 && r1) begin
            order.push_back(model_last == 0 ? 1 : 0);
            order.push_back(model_last == 0 ? 0 : 1);
        end else begin
            order.push_back(r0 ? 0 : 1);
        end
        foreach (order[k]) model_apply(cc[order[k]], exp_rd[order[k]], exp_er[order[k]]);
        model_last = order[order.size()-1];
        obs_rd = 8'h00;
        obs_err = 1'b0;
        req0 = r0; we0 = c0.we; addr0 = c0.addr; wdata0 = c0.wdata; wmask0 = c0.wmask;
        req1 = r1; we1 = c1.we; addr1 = c1.addr; wdata1 = c1.wdata; wmask1 = c1.wmask;
        got = 0;
        cyc = 0;
        while (got < order.size() && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (done0 || done1) begin
                id = done1 ? 1 : 0;
                chk("done_order", id, order[got]);
                chk("done_onehot", {done1, done0} == 2'b11, 0);
                chk("err", err, exp_er[id]);
                if (!cc[id].we) chk("rdata", rdata, exp_rd[id]);
                obs_rd = rdata;
                obs_err = err;
                if (id == 0) req0 = 0; else req1 = 0;
                got++;
            end
        end
        if (got < order.size()) chk("round_timeout", got, order.size());
        req0 = 0;
        req1 = 0;
    endtask

    vec_t       vecs[11];
    cmd_t       rc0, rc1, nc;
    logic [7:0] ord;
    logic       oer;
    int         seen;
    int         cyc;
    int         exp_id;
    int         t_first;
    int         t_second;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = '{0, '{1'b1, 3'd2, 8'hFF, 8'h3C}, 8'h00, 1'b0};
        vecs[1]  = '{0, '{1'b0, 3'd2, 8'h00, 8'h00}, 8'h3C, 1'b0};
        vecs[2]  = '{0, '{1'b1, 3'd2, 8'h00, 8'h04}, 8'h00, 1'b0};
        vecs[3]  = '{1, '{1'b0, 3'd2, 8'h00, 8'h00}, 8'h38, 1'b0};
        vecs[4]  = '{0, '{1'b1, 3'd7, 8'hFF, 8'hFF}, 8'h00, 1'b1};
        vecs[5]  = '{1, '{1'b0, 3'd7, 8'h00, 8'h00}, 8'h00, 1'b1};
        vecs[6]  = '{0, '{1'b0, 3'd2, 8'h00, 8'h00}, 8'h38, 1'b0};
        vecs[7]  = '{1, '{1'b1, 3'd4, 8'hA5, 8'h00}, 8'h00, 1'b0};
        vecs[8]  = '{0, '{1'b0, 3'd4, 8'h00, 8'h00}, 8'h00, 1'b0};
        vecs[9]  = '{1, '{1'b1, 3'd5, 8'hA5, 8'hF0}, 8'h00, 1'b0};
        vecs[10] = '{0, '{1'b0, 3'd5, 8'h00, 8'h00}, 8'hA0, 1'b0};
        nc = '{1'b0, 3'd0, 8'h00, 8'h00};
        model_reset();

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_done0", done0, 0);
        chk("rst_done1", done1, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rdata", rdata, 8'h00);
        rst_n = 1;
        @(negedge clk);

        // Single read of entry 5: done in the cycle after the access edge
        req0 = 1; we0 = 0; addr0 = 3'd5;
        @(negedge clk);
        chk("lat_done0_early", done0, 0);
        chk("lat_busy", busy, 1);
        @(negedge clk);
        chk("lat_done0", done0, 1);
        chk("lat_rdata", rdata, 8'h00);
        chk("lat_err", err, 0);
        req0 = 0;
        model_last = 0;
        @(negedge clk);
        chk("lat_done0_clear", done0, 0);
        chk("lat_busy_clear", busy, 0);

        // Table of single-requester transactions: masked writes, out of range, no-op mask
        foreach (vecs[i]) begin
            if (vecs[i].id == 0) do_round(1'b1, 1'b0, vecs[i].c, nc, ord, oer);
            else                 do_round(1'b0, 1'b1, nc, vecs[i].c, ord, oer);
            chk($sformatf("vec%0d_err", i), oer, vecs[i].exp_err);
            if (!vecs[i].c.we) chk($sformatf("vec%0d_rdata", i), ord, vecs[i].exp_rd);
        end

        // req1 left high one cycle past done1 is taken as a second request
        req1 = 1; we1 = 0; addr1 = 3'd2;
        seen = 0; cyc = 0; t_first = 0; t_second = 0;
        while (seen < 2 && cyc < 30) begin
            @(negedge clk);
            cyc++;
            if (done1) begin
                seen++;
                if (seen == 1) t_first = cyc; else t_second = cyc;
                chk("hold_rdata", rdata, 8'h38);
            end
            if (seen == 1 && cyc == t_first + 1) req1 = 1;
            else if (seen >= 1) req1 = 0;
        end
        req1 = 0;
        chk("hold_two_dones", seen, 2);
        chk("hold_spacing", t_second - t_first, 3);
        model_last = 1;

        // Randomized two-master rounds against the model
        for (int r = 0; r < 60; r++) begin
            int pat;
            pat = $urandom_range(1, 3);
            rc0 = '{1'($urandom), 3'($urandom), 8'($urandom), 8'($urandom)};
            rc1 = '{1'($urandom), 3'($urandom), 8'($urandom), 8'($urandom)};
            do_round(pat[0], pat[1], rc0, rc1, ord, oer);
        end

        // Reset while a write is in ACCESS: aborted, array cleared
        @(negedge clk);
        req0 = 1; we0 = 1; addr0 = 3'd1; wdata0 = 8'hFF; wmask0 = 8'hFF;
        @(negedge clk);
        chk("abort_busy_before", busy, 1);
        rst_n = 0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done0", done0, 0);
        req0 = 0;
        repeat (3) @(negedge clk);
        chk("abort_no_done", done0 | done1, 0);
        rst_n = 1;
        model_reset();
        @(negedge clk);
        chk("abort_busy_after", busy, 0);

        // Simultaneous first requests after reset: requester 0 first
        do_round(1'b1, 1'b1, '{1'b0, 3'd1, 8'h00, 8'h00}, '{1'b0, 3'd2, 8'h00, 8'h00}, ord, oer);
        for (int a = 0; a < DEPTH; a++) begin
            do_round(1'b0, 1'b1, nc, '{1'b0, 3'(a), 8'h00, 8'h00}, ord, oer);
            chk($sformatf("cleared_%0d", a), ord, 8'h00);
        end

        // Both held continuously: grants alternate
        req0 = 1; we0 = 0; addr0 = 3'd2;
        req1 = 1; we1 = 0; addr1 = 3'd3;
        exp_id = (model_last == 0) ? 1 : 0;
        seen = 0; cyc = 0;
        while (seen < 4 && cyc < 30) begin
            @(negedge clk);
            cyc++;
            if (done0 || done1) begin
                chk($sformatf("alt_%0d", seen), done1 ? 1 : 0, exp_id);
                model_last = exp_id;
                exp_id = 1 - exp_id;
                seen++;
            end
        end
        req0 = 0;
        req1 = 0;
        chk("alt_count", seen, 4);

        for (int r = 0; r < 20; r++) begin
            int pat;
            pat = $urandom_range(1, 3);
            rc0 = '{1'($urandom), 3'($urandom), 8'($urandom), 8'($urandom)};
            rc1 = '{1'($urandom), 3'($urandom), 8'($urandom), 8'($urandom)};
            do_round(pat[0], pat[1], rc0, rc1, ord, oer);
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
